nco_sweep_ctrl: RTL and testbench
=================================

# nco_sweep_ctrl

Frequency-sweep sequencer for the DSM transmit path. Holds a small register file loaded from the JTAG/AXI-lite configuration adapter and, on command, steps the NCO phase increment from a start value to a stop value in fixed increments, holding each value for a programmable dwell. Its `nco_step` output drives the `dsm_core` NCO step input directly in the `aclk` domain, replacing the static step word for swept-tone and spur-scan measurements.

## Interface
- `ACC_WIDTH`, 32, NCO phase-accumulator / step word width
- `DWELL_WIDTH`, 16, dwell counter width
- `aclk` in 1: system clock, the 100 MHz NCO clock
- `arst_n` in 1: asynchronous active-low reset
- `cfg_wr_en` in 1: register write strobe, one cycle
- `cfg_addr` in 2: register address. 0 = START, 1 = STOP, 2 = DELTA, 3 = DWELL
- `cfg_data` in ACC_WIDTH: write data. DWELL uses the low DWELL_WIDTH bits.
- `sweep_start` in 1: start pulse
- `sweep_abort` in 1: abort pulse
- `nco_step` out ACC_WIDTH: current step word to the NCO
- `nco_step_valid` out 1: one-cycle strobe on every `nco_step` change
- `busy` out 1: sweep in progress
- `done` out 1: one-cycle pulse when a sweep completes normally
- `point_count` out 16: number of points emitted in the current or last sweep, saturating at 0xFFFF

## Operation
- **Register file**
  - Writes are accepted in any state.
  - The active sweep uses shadow copies latched on an accepted start, so mid-sweep writes take effect only on the next sweep.
- **Direction**
  - The sweep goes up if shadow STOP ≥ START, otherwise down.
  - All arithmetic is unsigned, computed at ACC_WIDTH+1 bits.
- **FSM: IDLE → LOAD → DWELL ⇄ STEP → IDLE**
  - IDLE
    - `busy` = 0.
    - `sweep_start` while not busy → LOAD.
  - LOAD
    - Latch the shadow registers.
    - `nco_step` ← START, `point_count` ← 1, dwell counter ← DWELL.
    - → DWELL.
  - DWELL
    - Decrement the counter.
    - At 0 → STEP.
  - STEP, if `nco_step` == STOP
    - Pulse `done`.
    - → IDLE.
  - STEP, otherwise
    - next = `nco_step` ± DELTA.
    - If next passes or equals STOP (including wrap past 0 or 2^ACC_WIDTH−1, detected via the extra bit), next = STOP.
    - If DELTA == 0, next = STOP.
    - Load `nco_step`, pulse `nco_step_valid`, increment `point_count`, reload the dwell counter.
    - → DWELL.
- **Abort**
  - `sweep_abort` in any busy state → IDLE next cycle.
  - `nco_step` holds its value and there is no `done` pulse.
  - Abort and start in the same cycle: abort wins and the start is dropped.
- **Ignored start**: `sweep_start` while `busy` is ignored.
- **Same-cycle write and start**: a `cfg_wr_en` in the same cycle as an accepted start is visible to that sweep, because the write lands before LOAD latches.
- **START == STOP**: one point, then `done`.

## Timing
- **Reset values**
  - `nco_step` = 0
  - `nco_step_valid` = 0
  - `busy` = 0
  - `done` = 0
  - `point_count` = 0
  - FSM in IDLE
  - Register file and shadow copies = 0
- **Start to first point**
  - Start in cycle N puts LOAD in N+1.
  - `nco_step` = START and `nco_step_valid` = 1 in N+2.
  - `busy` = 1 from N+1.
- **Point spacing**: each point is held for DWELL+2 cycles (DWELL+1 in the DWELL state, 1 in STEP).
- **Completion**
  - `done` pulses in the STEP cycle in which the last point's dwell expires.
  - `busy` falls the following cycle.
  - `nco_step` stays at STOP.
- **Registered outputs**: all outputs are registered, with no combinational path from inputs.
- **Reset mid-sweep**: asynchronous return to the reset values.

## Configuration
- `NCO_SWEEP_PINGPONG_EN`
  - **Defined**
    - On reaching STOP, the sweep does not finish. It swaps direction and returns toward START, then back toward STOP, and so on.
    - Each endpoint arrival pulses `done` for one cycle.
    - `busy` stays 1 until `sweep_abort`.
    - START == STOP holds the point, pulsing `done` every DWELL+2 cycles.
  - **Undefined**: single-pass behaviour as described above.

## Test plan
- **Up sweep**: START=100, STOP=130, DELTA=10, DWELL=2, start pulse → `nco_step` 100, 110, 120, 130, each held 4 cycles. 4 `nco_step_valid` strobes, `done` once, `point_count`=4, final `nco_step`=130.
- **Down sweep with clamp**: START=130, STOP=100, DELTA=20 → points 130, 110, 100. Clamp on overshoot, `point_count`=3.
- **Wrap clamp**: START=0xFFFFFFF0, STOP=0xFFFFFFFF, DELTA=0x20 → points 0xFFFFFFF0, 0xFFFFFFFF. No wrap to a low value.
- **Abort**
  - Abort issued in the 2nd dwell of the up sweep → `busy` drops next cycle, `nco_step`=110, no `done`.
  - Start and abort in the same cycle → no sweep.
- **Mid-sweep write**: write STOP=200 during a sweep → the current sweep still ends at 130. The next sweep ends at 200. Start while busy is ignored.
- **Reset mid-sweep**: assert `arst_n`=0 mid-sweep → all outputs 0 immediately.
- **With `NCO_SWEEP_PINGPONG_EN`**: START=0, STOP=20, DELTA=10 → 0, 10, 20, 10, 0, 10 … with `done` at 20 and at 0, continuing until abort.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps the NCO phase increment from START to STOP by DELTA, holding each point for DWELL+2 cycles.
// Optional NCO_SWEEP_PINGPONG_EN: bounce between START and STOP until aborted, pulsing done at each endpoint.
module nco_sweep_ctrl #(
    parameter int ACC_WIDTH   = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                 aclk,
    input  logic                 arst_n,
    input  logic                 cfg_wr_en,
    input  logic [1:0]           cfg_addr,
    input  logic [ACC_WIDTH-1:0] cfg_data,
    input  logic                 sweep_start,
    input  logic                 sweep_abort,
    output logic [ACC_WIDTH-1:0] nco_step,
    output logic                 nco_step_valid,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          point_count
);
`ifdef NCO_SWEEP_PINGPONG_EN
    localparam bit PINGPONG = 1'b1;
`else
    localparam bit PINGPONG = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, DWELL, STEP} state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   start_q, stop_q, delta_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [ACC_WIDTH-1:0]   tgt_q, tgt_d, oth_q, oth_d, sh_delta_q, sh_delta_d;
    logic [DWELL_WIDTH-1:0] sh_dwell_q, sh_dwell_d, cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   step_q, step_d;
    logic [15:0]            pcnt_q, pcnt_d;
    logic                   valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [ACC_WIDTH:0]     sum, diff;
    logic [ACC_WIDTH-1:0]   dst, nxt;
    logic                   at_tgt, up, clamp, moved;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            start_q <= '0;
            stop_q  <= '0;
            delta_q <= '0;
            dwell_q <= '0;
        end else if (cfg_wr_en) begin
            if (cfg_addr == 2'd0) start_q <= cfg_data;
            if (cfg_addr == 2'd1) stop_q  <= cfg_data;
            if (cfg_addr == 2'd2) delta_q <= cfg_data;
            if (cfg_addr == 2'd3) dwell_q <= cfg_data[DWELL_WIDTH-1:0];
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = sweep_start ? LOAD : IDLE;
            LOAD:    state_d = DWELL;
            DWELL:   state_d = (cnt_q == '0) ? STEP : DWELL;
            default: state_d = (at_tgt && !PINGPONG) ? IDLE : DWELL;
        endcase
        if (sweep_abort) state_d = IDLE;
    end

    // At an endpoint in ping-pong mode the next point heads for the opposite endpoint.
    assign at_tgt = step_q == tgt_q;
    assign dst    = at_tgt ? oth_q : tgt_q;
    assign up     = dst >= step_q;
    assign sum    = {1'b0, step_q} + {1'b0, sh_delta_q};
    assign diff   = {1'b0, step_q} - {1'b0, sh_delta_q};
    assign clamp  = (sh_delta_q == '0) || (up ? (sum >= {1'b0, dst}) : (diff[ACC_WIDTH] || diff <= {1'b0, dst}));
    assign nxt    = clamp ? dst : (up ? sum[ACC_WIDTH-1:0] : diff[ACC_WIDTH-1:0]);
    assign moved  = nxt != step_q;

    always_comb begin
        tgt_d      = tgt_q;
        oth_d      = oth_q;
        sh_delta_d = sh_delta_q;
        sh_dwell_d = sh_dwell_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        pcnt_d     = pcnt_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        if (!sweep_abort) begin
            unique case (state_q)
                LOAD: begin
                    tgt_d      = stop_q;
                    oth_d      = start_q;
                    sh_delta_d = delta_q;
                    sh_dwell_d = dwell_q;
                    cnt_d      = dwell_q;
                    step_d     = start_q;
                    pcnt_d     = 16'd1;
                    valid_d    = 1'b1;
                end
                DWELL: begin
                    cnt_d  = cnt_q - DWELL_WIDTH'(1);
                    done_d = (cnt_q == '0) && at_tgt;
                end
                STEP: begin
                    if (!at_tgt || PINGPONG) begin
                        step_d  = nxt;
                        valid_d = moved;
                        pcnt_d  = (moved && pcnt_q != 16'hFFFF) ? pcnt_q + 16'd1 : pcnt_q;
                        cnt_d   = sh_dwell_q;
                        tgt_d   = at_tgt ? oth_q : tgt_q;
                        oth_d   = at_tgt ? tgt_q : oth_q;
                    end
                end
                default: ;
            endcase
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            tgt_q      <= '0;
            oth_q      <= '0;
            sh_delta_q <= '0;
            sh_dwell_q <= '0;
            cnt_q      <= '0;
            step_q     <= '0;
            pcnt_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tgt_q      <= tgt_d;
            oth_q      <= oth_d;
            sh_delta_q <= sh_delta_d;
            sh_dwell_q <= sh_dwell_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            pcnt_q     <= pcnt_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign nco_step       = step_q;
    assign nco_step_valid = valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign point_count    = pcnt_q;
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: scoreboard bench; a point-list model predicts every valid/done event with its cycle.
`timescale 1ns/1ps
module tb_nco_sweep_ctrl;
    localparam int W = 32;
`ifdef NCO_SWEEP_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic         aclk = 1'b0, arst_n = 1'b1, cfg_wr_en = 1'b0, sweep_start = 1'b0, sweep_abort = 1'b0;
    logic [1:0]   cfg_addr = '0;
    logic [W-1:0] cfg_data = '0;
    logic [W-1:0] nco_step;
    logic         nco_step_valid, busy, done;
    logic [15:0]  point_count;

    int checks = 0, failures = 0, cyc = 0;
    typedef struct {bit is_done; logic [W-1:0] val; int cnt; int at;} ev_t;
    ev_t sb[$];
    logic [W-1:0] mdl_val = '0;
    int mdl_cnt = 0, fin_end = 0;
    bit aborted = 1'b0;

    nco_sweep_ctrl dut (
        .aclk(aclk), .arst_n(arst_n), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .sweep_start(sweep_start), .sweep_abort(sweep_abort), .nco_step(nco_step),
        .nco_step_valid(nco_step_valid), .busy(busy), .done(done), .point_count(point_count)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Next point toward dst: move by d, land exactly on dst if it would be reached or passed.
    function automatic logic [W-1:0] toward(logic [W-1:0] cur, logic [W-1:0] dst, logic [W-1:0] d);
        longint c = cur, t = dst, k = d;
        if (k == 0) return dst;
        if (t >= c) return (c + k >= t) ? dst : W'(c + k);
        return (c - k <= t) ? dst : W'(c - k);
    endfunction

    function automatic void plan(logic [W-1:0] s, logic [W-1:0] e, logic [W-1:0] d, int dw, int t0, int lim);
        logic [W-1:0] cur = s, dst = e, oth = s, nx;
        int n = 1, t = t0 + 2, ts;
        fin_end = lim + 1;
        aborted = 1'b1;
        if (t > lim) return;
        sb.push_back('{1'b0, cur, n, t});
        mdl_val = cur;
        mdl_cnt = n;
        for (int k = 0; k < 1000; k++) begin
            ts = t + dw + 1;
            if (ts > lim) return;
            if (cur == dst) begin
                sb.push_back('{1'b1, cur, n, ts});
                if (!PP) begin
                    fin_end = ts + 1;
                    aborted = 1'b0;
                    return;
                end
                nx = dst; dst = oth; oth = nx;
            end
            nx = toward(cur, dst, d);
            t = ts + 1;
            if (t > lim) return;
            if (nx != cur) begin
                cur = nx;
                n = (n < 65535) ? n + 1 : n;
                sb.push_back('{1'b0, cur, n, t});
                mdl_val = cur;
                mdl_cnt = n;
            end
        end
    endfunction

    always @(negedge aclk) begin : monitor
        ev_t x;
        while (sb.size() != 0 && sb[0].at < cyc) begin
            x = sb.pop_front();
            checks++; failures++;
            $display("FAIL missed_event: expected %s step=%0h at cycle %0d, not observed", x.is_done ? "done" : "valid", x.val, x.at);
        end
        if (arst_n && (nco_step_valid || done)) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_event: cycle %0d valid=%0b done=%0b step=%0h", cyc, nco_step_valid, done, nco_step);
            end else begin
                x = sb.pop_front();
                chk("ev_done", done, x.is_done);
                chk("ev_valid", nco_step_valid, !x.is_done);
                chk("ev_step", nco_step, x.val);
                chk("ev_count", point_count, x.cnt);
                chk("ev_cycle", cyc, x.at);
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(logic [1:0] a, logic [W-1:0] v);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_data = v;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic cfg(logic [W-1:0] s, logic [W-1:0] e, logic [W-1:0] d, int dw);
        wr(2'd0, s); wr(2'd1, e); wr(2'd2, d); wr(2'd3, W'(dw));
    endtask

    // mode 0: configure then start; 1: START written in the start cycle; 2: mid-sweep STOP write + ignored start; 3: reuse registers
    task automatic sweep(logic [W-1:0] s, logic [W-1:0] e, logic [W-1:0] d, int dw, int ab, int mode);
        int t0, lim;
        if (mode == 0 || mode == 2) cfg(s, e, d, dw);
        if (mode == 1) cfg(~s, e, d, dw);
        if (PP && ab < 0) ab = 6 * (dw + 2) + 3;
        t0 = cyc;
        lim = (ab < 0) ? 32'h3FFF_FFFF : t0 + ab;
        plan(s, e, d, dw, t0, lim);
        sweep_start = 1'b1;
        if (mode == 1) begin
            cfg_wr_en = 1'b1; cfg_addr = 2'd0; cfg_data = s;
        end
        tick();
        sweep_start = 1'b0;
        cfg_wr_en = 1'b0;
        @(negedge aclk);
        chk("busy_rise", busy, 1);
        if (mode == 2) begin
            wait_cyc(t0 + 4);
            sweep_start = 1'b1;
            cfg_wr_en = 1'b1; cfg_addr = 2'd1; cfg_data = e + 70;
            tick();
            sweep_start = 1'b0;
            cfg_wr_en = 1'b0;
        end
        if (aborted) begin
            wait_cyc(lim);
            sweep_abort = 1'b1;
            tick();
            sweep_abort = 1'b0;
        end
        wait_cyc(fin_end);
        @(negedge aclk);
        chk("busy_end", busy, 0);
        chk("step_end", nco_step, mdl_val);
        chk("count_end", point_count, mdl_cnt);
        chk("sb_drain", sb.size(), 0);
        sb.delete();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] s, e, d;
        int span, dw, ab, t0;
        #2 arst_n = 1'b0;
        #2;
        chk("rst_step", nco_step, 0);
        chk("rst_valid", nco_step_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", point_count, 0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        arst_n = 1'b1;
        tick();

        sweep(100, 130, 10, 2, -1, 0);
        sweep(130, 100, 20, 2, -1, 0);
        sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 2, -1, 0);
        sweep(100, 130, 10, 2, 7, 0);

        cfg(100, 130, 10, 2);
        sweep_start = 1'b1; sweep_abort = 1'b1;
        tick();
        sweep_start = 1'b0; sweep_abort = 1'b0;
        repeat (4) begin
            @(negedge aclk);
            chk("start_abort_busy", busy, 0);
            tick();
        end
        chk("start_abort_step", nco_step, mdl_val);

        sweep(100, 130, 10, 2, -1, 2);
        sweep(100, 200, 10, 2, -1, 3);
        sweep(55, 10, 0, 1, -1, 1);
        sweep(77, 77, 5, 0, -1, 0);
`ifdef NCO_SWEEP_PINGPONG_EN
        sweep(0, 20, 10, 1, 40, 0);
`endif

        for (int i = 0; i < 10; i++) begin
            span = $urandom_range(0, 120);
            s = $urandom_range(0, 1) ? 32'hFFFF_FF80 + W'($urandom_range(0, 127)) : W'($urandom_range(0, 300));
            if ($urandom_range(0, 1) == 1) e = (s > 32'hFFFF_FFFF - W'(span)) ? 32'hFFFF_FFFF : s + W'(span);
            else e = (s < W'(span)) ? '0 : s - W'(span);
            d = W'($urandom_range(0, 40));
            dw = $urandom_range(0, 3);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 25)) : -1;
            sweep(s, e, d, dw, ab, 0);
        end

        cfg(100, 130, 10, 2);
        t0 = cyc;
        plan(100, 130, 10, 2, t0, t0 + 8);
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        wait_cyc(t0 + 9);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_step", nco_step, 0);
        chk("mid_rst_valid", nco_step_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_count", point_count, 0);
        chk("mid_rst_drain", sb.size(), 0);
        sb.delete();
        #2 arst_n = 1'b1;
        tick();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
